// File: rtl/ibex_fp_pkg.sv
// +--------------------------------------------------------------+
// | ibex_fp_pkg: FP op encoding, latency classes, defaults r1.0  |
// +--------------------------------------------------------------+
`default_nettype none

package ibex_fp_pkg;

  typedef enum logic [5:0] {
    FPU_NOP      = 6'd0,
    FPU_ADD      = 6'd1,
    FPU_SUB      = 6'd2,
    FPU_MUL      = 6'd3,
    FPU_MADD     = 6'd4,
    FPU_MSUB     = 6'd5,
    FPU_NMADD    = 6'd6,
    FPU_NMSUB    = 6'd7,
    FPU_DIV      = 6'd8,
    FPU_SQRT     = 6'd9,
    FPU_MIN      = 6'd10,
    FPU_MAX      = 6'd11,
    FPU_SGNJ     = 6'd12,
    FPU_SGNJN    = 6'd13,
    FPU_SGNJX    = 6'd14,
    FPU_MOVE_X2F = 6'd15,
    FPU_MOVE_F2X = 6'd16,
    FPU_CMP_EQ   = 6'd17,
    FPU_CMP_LT   = 6'd18,
    FPU_CMP_LE   = 6'd19,
    FPU_FCLASS   = 6'd20,
    FPU_I2F      = 6'd21,
    FPU_I2F_U    = 6'd22,
    FPU_F2I      = 6'd23,
    FPU_F2I_U    = 6'd24
  } fpu_op_e;

  typedef enum logic [2:0] {
    LAT_SINGLE = 3'd0,
    LAT_ADD    = 3'd1,
    LAT_MUL    = 3'd2,
    LAT_FMA    = 3'd3,
    LAT_CVT    = 3'd4,
    LAT_ITER   = 3'd5,
    LAT_NONE   = 3'd6
  } fpu_lat_class_e;

  localparam int unsigned DEF_TAG_W   = 5;
  localparam int unsigned DEF_ADD_LAT = 2;
  localparam int unsigned DEF_MUL_LAT = 3;
  localparam int unsigned DEF_FMA_LAT = 4;
  localparam int unsigned DEF_CVT_LAT = 2;
  localparam int unsigned DEF_MAX_LAT = 4;

  // Unused encodings fall into LAT_NONE and behave like NOP.
  function automatic fpu_lat_class_e op_to_class(input logic [5:0] op);
    case (op)
      FPU_ADD, FPU_SUB:                                 return LAT_ADD;
      FPU_MUL:                                          return LAT_MUL;
      FPU_MADD, FPU_MSUB, FPU_NMADD, FPU_NMSUB:         return LAT_FMA;
      FPU_I2F, FPU_I2F_U, FPU_F2I, FPU_F2I_U:           return LAT_CVT;
      FPU_DIV, FPU_SQRT:                                return LAT_ITER;
      FPU_MIN, FPU_MAX, FPU_SGNJ, FPU_SGNJN, FPU_SGNJX,
      FPU_MOVE_X2F, FPU_MOVE_F2X, FPU_CMP_EQ, FPU_CMP_LT,
      FPU_CMP_LE, FPU_FCLASS:                           return LAT_SINGLE;
      default:                                          return LAT_NONE;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/fpu_wb_resv.sv
// +--------------------------------------------------------------+
// | fpu_wb_resv: writeback-slot reservation shift register r1.0  |
// +--------------------------------------------------------------+
`default_nettype none

module fpu_wb_resv #(
  parameter int unsigned TAG_W   = 5,
  parameter int unsigned MAX_LAT = 4,
  parameter int unsigned LW      = $clog2(MAX_LAT + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic [LW-1:0]    lat_i,
  input  logic             wr_en_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  output logic             free_o,
  output logic             next_valid_o,
  output logic             wb_valid_o,
  output logic [TAG_W-1:0] wb_tag_o,
  output logic             any_valid_o
);

  logic [MAX_LAT:1]            vld_q, vld_d, vld_sh;
  logic [MAX_LAT:1][TAG_W-1:0] tag_q, tag_d, tag_sh;

  for (genvar k = 1; k < MAX_LAT; k++) begin : g_shift
    assign vld_sh[k] = vld_q[k+1];
    assign tag_sh[k] = tag_q[k+1];
  end
  assign vld_sh[MAX_LAT] = 1'b0;
  assign tag_sh[MAX_LAT] = '0;

  // Slot k of the shifted view is the result due k cycles from now.
  always_comb begin
    free_o = 1'b0;
    vld_d  = vld_sh;
    tag_d  = tag_sh;
    for (int k = 1; k <= MAX_LAT; k++) begin
      if (lat_i == LW'(k)) begin
        free_o = ~vld_sh[k];
        if (wr_en_i) begin
          vld_d[k] = 1'b1;
          tag_d[k] = wr_tag_i;
        end
      end
    end
    if (flush_i) vld_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= '0;
      tag_q <= '0;
    end else begin
      vld_q <= vld_d;
      tag_q <= tag_d;
    end
  end

  assign next_valid_o = vld_sh[1];
  assign wb_valid_o   = vld_q[1];
  assign wb_tag_o     = tag_q[1];
  assign any_valid_o  = |vld_q;

endmodule

`default_nettype wire

// File: rtl/fpu_issue_sched.sv
// +--------------------------------------------------------------+
// | fpu_issue_sched: FP issue scheduler, pipe vs div/sqrt, r1.0  |
// | FPU_ISSUE_PERF_EN adds issue/stall performance counters.     |
// +--------------------------------------------------------------+
`default_nettype none

module fpu_issue_sched
  import ibex_fp_pkg::*;
#(
  parameter int unsigned TAG_W   = DEF_TAG_W,
  parameter int unsigned ADD_LAT = DEF_ADD_LAT,
  parameter int unsigned MUL_LAT = DEF_MUL_LAT,
  parameter int unsigned FMA_LAT = DEF_FMA_LAT,
  parameter int unsigned CVT_LAT = DEF_CVT_LAT,
  parameter int unsigned MAX_LAT = DEF_MAX_LAT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [5:0]       req_op_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             pipe_issue_o,
  output logic [5:0]       pipe_op_o,
  output logic             div_start_o,
  output logic             div_sqrt_o,
  input  logic             div_done_i,
  output logic             wb_valid_o,
  output logic [TAG_W-1:0] wb_tag_o,
  output logic             wb_from_div_o,
`ifdef FPU_ISSUE_PERF_EN
  output logic [31:0]      perf_issued_o,
  output logic [31:0]      perf_stall_o,
`endif
  output logic             busy_o
);

  localparam int unsigned LW = $clog2(MAX_LAT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  fpu_lat_class_e   op_class;
  logic [LW-1:0]    req_lat;
  logic             is_pipe, is_div, is_nop;
  logic             slot_free, next_valid, resv_wb_valid, resv_any;
  logic [TAG_W-1:0] resv_wb_tag;
  logic             accept, pipe_acc, div_acc, blocked;
  logic             pipe_wb, div_wb;
  logic [1:0]       state_q, state_d;
  logic             discard_q, discard_d;
  logic [TAG_W-1:0] div_tag_q, div_tag_d;

  always_comb begin
    op_class = op_to_class(req_op_i);
    req_lat  = LW'(1);
    is_pipe  = 1'b0;
    is_div   = 1'b0;
    is_nop   = 1'b0;
    case (op_class)
      LAT_SINGLE: is_pipe = 1'b1;
      LAT_ADD:    begin is_pipe = 1'b1; req_lat = LW'(ADD_LAT); end
      LAT_MUL:    begin is_pipe = 1'b1; req_lat = LW'(MUL_LAT); end
      LAT_FMA:    begin is_pipe = 1'b1; req_lat = LW'(FMA_LAT); end
      LAT_CVT:    begin is_pipe = 1'b1; req_lat = LW'(CVT_LAT); end
      LAT_ITER:   is_div  = 1'b1;
      default:    is_nop  = 1'b1;
    endcase
  end

  fpu_wb_resv #(
    .TAG_W   (TAG_W),
    .MAX_LAT (MAX_LAT),
    .LW      (LW)
  ) u_resv (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .lat_i        (req_lat),
    .wr_en_i      (pipe_acc),
    .wr_tag_i     (req_tag_i),
    .free_o       (slot_free),
    .next_valid_o (next_valid),
    .wb_valid_o   (resv_wb_valid),
    .wb_tag_o     (resv_wb_tag),
    .any_valid_o  (resv_any)
  );

  // A held div result blocks pipe issue so it drains within MAX_LAT cycles.
  always_comb begin
    blocked     = rst_i | flush_i;
    req_ready_o = ~blocked & (is_nop
                | (is_pipe & slot_free & (state_q != S_HOLD))
                | (is_div & ((state_q == S_IDLE) | (state_q == S_WB))));
    accept       = req_valid_i & req_ready_o;
    pipe_acc     = accept & is_pipe;
    div_acc      = accept & is_div;
    pipe_issue_o = pipe_acc;
    pipe_op_o    = pipe_acc ? req_op_i : 6'd0;
    div_start_o  = div_acc;
    div_sqrt_o   = div_acc & (req_op_i == FPU_SQRT);
  end

  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    div_tag_d = div_tag_q;
    case (state_q)
      S_IDLE: begin
        if (div_acc) begin
          state_d   = S_BUSY;
          div_tag_d = req_tag_i;
          discard_d = 1'b0;
        end
      end
      S_BUSY: begin
        if (flush_i) begin
          if (div_done_i) begin
            state_d   = S_IDLE;
            discard_d = 1'b0;
          end else begin
            discard_d = 1'b1;
          end
        end else if (div_done_i) begin
          state_d   = discard_q ? S_IDLE : S_HOLD;
          discard_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (flush_i) state_d = S_IDLE;
        else if (!next_valid) state_d = S_WB;
      end
      default: begin
        if (div_acc) begin
          state_d   = S_BUSY;
          div_tag_d = req_tag_i;
          discard_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      discard_q <= 1'b0;
      div_tag_q <= '0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      div_tag_q <= div_tag_d;
    end
  end

  always_comb begin
    pipe_wb       = resv_wb_valid & ~blocked;
    div_wb        = (state_q == S_WB) & ~blocked;
    wb_valid_o    = pipe_wb | div_wb;
    wb_from_div_o = div_wb;
    wb_tag_o      = div_wb ? div_tag_q : (pipe_wb ? resv_wb_tag : '0);
    busy_o        = ~rst_i & (resv_any | (state_q != S_IDLE));
  end

`ifdef FPU_ISSUE_PERF_EN
  logic [31:0] perf_issued_q, perf_issued_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_issued_d = perf_issued_q;
    perf_stall_d  = perf_stall_q;
    if (accept && (perf_issued_q != 32'hFFFF_FFFF)) perf_issued_d = perf_issued_q + 32'd1;
    if (req_valid_i && !req_ready_o && (perf_stall_q != 32'hFFFF_FFFF))
      perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_issued_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_issued_q <= perf_issued_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_issued_o = perf_issued_q;
  assign perf_stall_o  = perf_stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fpu_issue_sched.sv
// +--------------------------------------------------------------+
// | tb_fpu_issue_sched: scoreboard bench for fpu_issue_sched r1.0 |
// +--------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_fpu_issue_sched;
  import ibex_fp_pkg::*;

  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1, flush_i = 1'b0, req_valid_i = 1'b0, div_done_i = 1'b0;
  logic [5:0]       req_op_i = 6'd0;
  logic [TAG_W-1:0] req_tag_i = '0;
  logic             req_ready_o, pipe_issue_o, div_start_o, div_sqrt_o;
  logic             wb_valid_o, wb_from_div_o, busy_o;
  logic [5:0]       pipe_op_o;
  logic [TAG_W-1:0] wb_tag_o;
`ifdef FPU_ISSUE_PERF_EN
  logic [31:0]      perf_issued_o, perf_stall_o;
`endif

  fpu_issue_sched #(.TAG_W(TAG_W)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .flush_i       (flush_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_op_i      (req_op_i),
    .req_tag_i     (req_tag_i),
    .pipe_issue_o  (pipe_issue_o),
    .pipe_op_o     (pipe_op_o),
    .div_start_o   (div_start_o),
    .div_sqrt_o    (div_sqrt_o),
    .div_done_i    (div_done_i),
    .wb_valid_o    (wb_valid_o),
    .wb_tag_o      (wb_tag_o),
    .wb_from_div_o (wb_from_div_o),
`ifdef FPU_ISSUE_PERF_EN
    .perf_issued_o (perf_issued_o),
    .perf_stall_o  (perf_stall_o),
`endif
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               cyc;
    logic [TAG_W-1:0] tag;
    logic             from_div;
  } wb_t;

  wb_t exp_q[$];
  int  cyc = 0;
  int  n_vec = 0;
  int  n_err = 0;

  logic       exp_ready = 1'b0, exp_busy = 1'b0;
  logic [8:0] exp_iss = '0;

  // Div unit model: 0 idle, 1 computing, 2 result held, 3 result written.
  int               dstate = 0;
  bit               discard = 0;
  logic [TAG_W-1:0] dtag = '0;

  // Writeback latency per op: 0 = none, -1 = iterative unit.
  function automatic int lat_of(input logic [5:0] op);
    case (op)
      FPU_ADD, FPU_SUB:                         return 2;
      FPU_MUL:                                  return 3;
      FPU_MADD, FPU_MSUB, FPU_NMADD, FPU_NMSUB: return 4;
      FPU_I2F, FPU_I2F_U, FPU_F2I, FPU_F2I_U:   return 2;
      FPU_DIV, FPU_SQRT:                        return -1;
      FPU_MIN, FPU_MAX, FPU_SGNJ, FPU_SGNJN, FPU_SGNJX, FPU_MOVE_X2F,
      FPU_MOVE_F2X, FPU_CMP_EQ, FPU_CMP_LT, FPU_CMP_LE, FPU_FCLASS: return 1;
      default:                                  return 0;
    endcase
  endfunction

  function automatic bit slot_taken(input int c);
    foreach (exp_q[i]) if (exp_q[i].cyc == c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void cancel_from(input int c);
    for (int i = exp_q.size() - 1; i >= 0; i--)
      if (exp_q[i].cyc >= c) exp_q.delete(i);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit f, input bit v, input logic [5:0] op,
                      input logic [TAG_W-1:0] tg, input bit dn);
    int L;
    bit acc, any_pipe;
    @(posedge clk);
    cyc++;
    #1;
    rst_i = r; flush_i = f; req_valid_i = v; req_op_i = op; req_tag_i = tg; div_done_i = dn;
    L = lat_of(op);
    any_pipe = 1'b0;
    foreach (exp_q[i]) if (!exp_q[i].from_div && exp_q[i].cyc >= cyc) any_pipe = 1'b1;
    if (r) begin
      exp_ready = 1'b0;
      exp_busy  = 1'b0;
      exp_iss   = '0;
      cancel_from(cyc);
      dstate  = 0;
      discard = 1'b0;
      return;
    end
    exp_busy = any_pipe || (dstate != 0);
    if (f)           exp_ready = 1'b0;
    else if (L == 0) exp_ready = 1'b1;
    else if (L > 0)  exp_ready = !slot_taken(cyc + L) && (dstate != 2);
    else             exp_ready = (dstate == 0) || (dstate == 3);
    acc = v && exp_ready;
    exp_iss = {acc && (L > 0), acc && (L < 0), acc && (op == FPU_SQRT),
               (acc && (L > 0)) ? op : 6'd0};
    if (f) cancel_from(cyc);
    if (acc && (L > 0)) exp_q.push_back('{cyc + L, tg, 1'b0});
    case (dstate)
      0: if (acc && (L < 0)) begin dstate = 1; dtag = tg; discard = 1'b0; end
      1: begin
        if (f) begin
          if (dn) begin dstate = 0; discard = 1'b0; end
          else discard = 1'b1;
        end else if (dn) begin
          dstate  = discard ? 0 : 2;
          discard = 1'b0;
        end
      end
      2: begin
        if (f) dstate = 0;
        else if (!slot_taken(cyc + 1)) begin
          exp_q.push_back('{cyc + 1, dtag, 1'b1});
          dstate = 3;
        end
      end
      default: begin
        if (acc && (L < 0)) begin dstate = 1; dtag = tg; discard = 1'b0; end
        else dstate = 0;
      end
    endcase
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, FPU_NOP, '0, 0);
  endtask

  // Monitor: compares every cycle's outputs and pops the due writeback.
  initial begin
    int idx;
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        chk("ready", 32'(req_ready_o), 32'(exp_ready));
        chk("busy", 32'(busy_o), 32'(exp_busy));
        chk("issue", 32'({pipe_issue_o, div_start_o, div_sqrt_o, pipe_op_o}), 32'(exp_iss));
        idx = -1;
        foreach (exp_q[i]) if (exp_q[i].cyc == cyc) idx = i;
        if (idx >= 0) begin
          chk("wb", 32'({wb_valid_o, wb_from_div_o, wb_tag_o}),
              32'({1'b1, exp_q[idx].from_div, exp_q[idx].tag}));
          exp_q.delete(idx);
        end else begin
          chk("wb_idle", 32'(wb_valid_o), 32'd0);
        end
      end
    end
  end

  initial begin
    bit r, f, v, dn;
    logic [5:0] op;
    logic [TAG_W-1:0] tg;
    step(1, 0, 0, FPU_NOP, '0, 0);
    step(1, 0, 0, FPU_NOP, '0, 0);
    // back-to-back ADDs
    step(0, 0, 1, FPU_ADD, 5'd1, 0);
    step(0, 0, 1, FPU_ADD, 5'd2, 0);
    step(0, 0, 1, FPU_ADD, 5'd3, 0);
    idle(4);
    // FMA then colliding single-cycle op
    step(0, 0, 1, FPU_MADD, 5'd5, 0);
    idle(2);
    step(0, 0, 1, FPU_MIN, 5'd6, 0);
    step(0, 0, 1, FPU_MIN, 5'd6, 0);
    idle(4);
    // DIV result deferred behind a MUL writeback
    step(0, 0, 1, FPU_DIV, 5'd9, 0);
    idle(2);
    step(0, 0, 1, FPU_MUL, 5'd4, 0);
    idle(1);
    step(0, 0, 0, FPU_NOP, '0, 1);
    step(0, 0, 1, FPU_ADD, 5'd7, 0);
    step(0, 0, 1, FPU_SQRT, 5'd10, 0);
    step(0, 0, 1, FPU_DIV, 5'd11, 0);
    step(0, 0, 1, FPU_DIV, 5'd11, 0);
    step(0, 0, 1, FPU_DIV, 5'd11, 1);
    step(0, 0, 1, FPU_DIV, 5'd11, 0);
    step(0, 0, 1, FPU_DIV, 5'd11, 0);
    step(0, 0, 1, FPU_DIV, 5'd11, 0);
    idle(2);
    step(0, 0, 0, FPU_NOP, '0, 1);
    idle(4);
    // flush kills an in-flight MUL
    step(0, 0, 1, FPU_MUL, 5'd4, 0);
    step(0, 1, 1, FPU_ADD, 5'd8, 0);
    idle(4);
    // flush while dividing drops the next done
    step(0, 0, 1, FPU_DIV, 5'd12, 0);
    idle(1);
    step(0, 1, 0, FPU_NOP, '0, 0);
    idle(1);
    step(0, 0, 0, FPU_NOP, '0, 1);
    step(0, 0, 1, FPU_DIV, 5'd13, 0);
    idle(1);
    step(0, 0, 0, FPU_NOP, '0, 1);
    idle(4);
    // reset with a MUL and a DIV in flight
    step(0, 0, 1, FPU_MUL, 5'd3, 0);
    step(0, 0, 1, FPU_SQRT, 5'd14, 0);
    step(1, 0, 1, FPU_ADD, 5'd2, 0);
    step(0, 0, 0, FPU_NOP, '0, 1);
    idle(4);
    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      r  = ($urandom_range(0, 299) == 0);
      f  = ($urandom_range(0, 39) == 0);
      v  = ($urandom_range(0, 3) != 0);
      op = 6'($urandom_range(0, 26));
      tg = TAG_W'($urandom);
      dn = (dstate == 1) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 15) == 0);
      step(r, f, v, op, tg, dn);
    end
    idle(8);
    @(negedge clk);
    #1;
    chk("drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
